// File: rtl/rf_pkg.sv
// Shared constants and helpers for the rf_bypass_sb register file.
// Optional build macro RF_ZERO_REG_EN is consumed by rf_bypass_sb.
package rf_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;

  // Bit positions inside the internal err_cause debug vector
  localparam int ERR_RANGE  = 0;
  localparam int ERR_WAW    = 1;
  localparam int ERR_CAUSES = 2;

  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: reserve sets, write-back clears, reserve wins on the same register.
// Also flags a reserve that hits a register still busy and not being written this cycle.
module rf_scoreboard #(
  parameter int SEL_W   = 3,
  parameter int NUM_ENT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rsv,
  input  logic [SEL_W-1:0]   rsvregsel,
  input  logic               clr,
  input  logic [SEL_W-1:0]   clrregsel,
  output logic [NUM_ENT-1:0] busy,
  output logic               waw
);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr) busy[clrregsel] <= 1'b0;
      // Later assignment wins: a new producer overrides the retiring one
      if (rsv) busy[rsvregsel] <= 1'b1;
    end
  end

  assign waw = rsv && busy[rsvregsel] && !(clr && (clrregsel == rsvregsel));

endmodule

// File: rtl/rf_bypass_sb.sv
// 2R/1W register file with write-to-read bypass and a busy-bit scoreboard.
// Build macro RF_ZERO_REG_EN hardwires r0 to zero and ignores writes/reserves to it.
module rf_bypass_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SEL_W    = sel_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  read1regsel,
  input  logic [SEL_W-1:0]  read2regsel,
  output logic [DATA_W-1:0] read1data,
  output logic [DATA_W-1:0] read2data,
  output logic              read1busy,
  output logic              read2busy,
  input  logic [SEL_W-1:0]  writeregsel,
  input  logic [DATA_W-1:0] writedata,
  input  logic              write,
  input  logic              rsv,
  input  logic [SEL_W-1:0]  rsvregsel,
  output logic              err
);

  localparam int NUM_ENT = 1 << SEL_W;

`ifdef RF_ZERO_REG_EN
  localparam logic ZERO_REG = 1'b1;
`else
  localparam logic ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0]     regs [NUM_ENT];
  logic [NUM_ENT-1:0]    busy;
  logic                  waw;
  logic                  wr_en;
  logic                  rsv_en;
  logic [ERR_CAUSES-1:0] err_cause;

  function automatic logic in_range(input logic [SEL_W-1:0] sel);
    return {{(32-SEL_W){1'b0}}, sel} < 32'(NUM_REGS);
  endfunction

  function automatic logic hard0(input logic [SEL_W-1:0] sel);
    return ZERO_REG && (sel == '0);
  endfunction

  function automatic logic hits_write(input logic [SEL_W-1:0] sel);
    return write && (writeregsel == sel);
  endfunction

  function automatic logic [DATA_W-1:0] rd_data(input logic [SEL_W-1:0] sel);
    if (!in_range(sel) || hard0(sel)) return '0;
    else if (hits_write(sel))         return writedata;
    else                              return regs[sel];
  endfunction

  function automatic logic rd_busy(input logic [SEL_W-1:0] sel);
    return in_range(sel) && !hard0(sel) && busy[sel] && !hits_write(sel);
  endfunction

  assign wr_en  = write && in_range(writeregsel) && !hard0(writeregsel);
  assign rsv_en = rsv && in_range(rsvregsel) && !hard0(rsvregsel);

  // Stage boundary: architectural state updates on the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENT; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[writeregsel] <= writedata;
    end
  end

  rf_scoreboard #(
    .SEL_W   (SEL_W),
    .NUM_ENT (NUM_ENT)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rsv       (rsv_en),
    .rsvregsel (rsvregsel),
    .clr       (wr_en),
    .clrregsel (writeregsel),
    .busy      (busy),
    .waw       (waw)
  );

  assign read1data = rd_data(read1regsel);
  assign read2data = rd_data(read2regsel);
  assign read1busy = rd_busy(read1regsel);
  assign read2busy = rd_busy(read2regsel);

  always_comb begin
    err_cause            = '0;
    err_cause[ERR_RANGE] = !in_range(read1regsel) || !in_range(read2regsel) ||
                           (write && !in_range(writeregsel)) ||
                           (rsv && !in_range(rsvregsel));
    err_cause[ERR_WAW]   = waw;
  end

  // Stage boundary: one-cycle error pulse
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= |err_cause;
  end

endmodule

// File: tb/tb_rf_bypass_sb.sv
// Directed bench for rf_bypass_sb with NUM_REGS=6 so selects 6 and 7 are out of range.
// Expected r0 behaviour follows RF_ZERO_REG_EN when the bench is built with it.
module tb_rf_bypass_sb;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 6;
  localparam int SEL_W    = 3;

`ifdef RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [SEL_W-1:0]  read1regsel, read2regsel, writeregsel, rsvregsel;
  logic [DATA_W-1:0] read1data, read2data, writedata;
  logic              read1busy, read2busy, write, rsv, err;

  int checks   = 0;
  int failures = 0;

  rf_bypass_sb #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .read1regsel (read1regsel),
    .read2regsel (read2regsel),
    .read1data   (read1data),
    .read2data   (read2data),
    .read1busy   (read1busy),
    .read2busy   (read2busy),
    .writeregsel (writeregsel),
    .writedata   (writedata),
    .write       (write),
    .rsv         (rsv),
    .rsvregsel   (rsvregsel),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one edge, then let outputs settle before the next drive/check
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; rsv = 1'b0;
    read1regsel = '0; read2regsel = '0; writeregsel = '0; rsvregsel = '0;
    writedata = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    read1regsel = 3'd3; read2regsel = 3'd3; #1;
    chk("rst_rd1", read1data, 0);
    chk("rst_rd2", read2data, 0);
    chk("rst_busy1", read1busy, 0);
    chk("rst_busy2", read2busy, 0);
    chk("rst_err", err, 0);

    // Same-cycle bypass, then stored value
    write = 1'b1; writeregsel = 3'd5; writedata = 16'hBEEF; read1regsel = 3'd5; #1;
    chk("byp_rd1", read1data, 16'hBEEF);
    chk("byp_rd2_other", read2data, 0);
    tick();
    write = 1'b0; #1;
    chk("stored_r5", read1data, 16'hBEEF);
    chk("stored_err", err, 0);

    // Reserve r2, stale until write-back bypass clears it
    rsv = 1'b1; rsvregsel = 3'd2;
    tick();
    rsv = 1'b0; read1regsel = 3'd2; #1;
    chk("rsv_busy_c1", read1busy, 1);
    chk("rsv_data_c1", read1data, 0);
    tick(); tick();
    write = 1'b1; writeregsel = 3'd2; writedata = 16'h0042; #1;
    chk("wb_busy_c3", read1busy, 0);
    chk("wb_data_c3", read1data, 16'h0042);
    tick();
    write = 1'b0; #1;
    chk("wb_busy_c4", read1busy, 0);
    chk("wb_data_c4", read1data, 16'h0042);
    chk("wb_err", err, 0);

    // WAW double reserve on r4
    rsv = 1'b1; rsvregsel = 3'd4;
    tick();
    #1;
    chk("waw_err_first", err, 0);
    tick();
    rsv = 1'b0; read1regsel = 3'd4; #1;
    chk("waw_err_pulse", err, 1);
    chk("waw_busy_r4", read1busy, 1);
    tick();
    chk("waw_err_clear", err, 0);

    // Write and reserve same register: data lands, busy stays set
    write = 1'b1; writeregsel = 3'd1; writedata = 16'h1111; rsv = 1'b1; rsvregsel = 3'd1;
    tick();
    write = 1'b0; rsv = 1'b0; read1regsel = 3'd1; #1;
    chk("wr_rsv_same_data", read1data, 16'h1111);
    chk("wr_rsv_same_busy", read1busy, 1);
    chk("wr_rsv_same_err", err, 0);

    // Write r4 (clears its busy) and reserve r3 in the same cycle
    write = 1'b1; writeregsel = 3'd4; writedata = 16'h4444; rsv = 1'b1; rsvregsel = 3'd3;
    tick();
    write = 1'b0; rsv = 1'b0; read1regsel = 3'd4; read2regsel = 3'd3; #1;
    chk("wr_rsv_diff_d4", read1data, 16'h4444);
    chk("wr_rsv_diff_b4", read1busy, 0);
    chk("wr_rsv_diff_b3", read2busy, 1);
    chk("wr_rsv_diff_err", err, 0);

    // Out-of-range write and read
    write = 1'b1; writeregsel = 3'd7; writedata = 16'hABCD; read1regsel = 3'd7; #1;
    chk("oor_rd_data", read1data, 0);
    chk("oor_rd_busy", read1busy, 0);
    tick();
    write = 1'b0; writeregsel = 3'd0; read1regsel = 3'd5; #1;
    chk("oor_wr_err", err, 1);
    chk("oor_wr_nochg", read1data, 16'hBEEF);
    read2regsel = 3'd6; #1;
    chk("oor_rd2_data", read2data, 0);
    chk("oor_rd2_busy", read2busy, 0);
    tick();
    read2regsel = 3'd3; #1;
    chk("oor_rd_err", err, 1);
    rsv = 1'b1; rsvregsel = 3'd6;
    tick();
    rsv = 1'b0; rsvregsel = 3'd0; #1;
    chk("oor_rsv_err", err, 1);
    tick();
    chk("oor_err_clear", err, 0);

    // Register 0 behaviour
    write = 1'b1; writeregsel = 3'd0; writedata = 16'hFFFF; read1regsel = 3'd0; #1;
    chk("r0_same", read1data, ZR ? 0 : 16'hFFFF);
    tick();
    write = 1'b0; #1;
    chk("r0_next", read1data, ZR ? 0 : 16'hFFFF);
    rsv = 1'b1; rsvregsel = 3'd0;
    tick(); tick();
    rsv = 1'b0; #1;
    chk("r0_waw_err", err, ZR ? 0 : 1);
    chk("r0_busy", read1busy, ZR ? 0 : 1);
    tick();

    // Reset with a pending reservation and a would-be WAW
    read1regsel = 3'd3; read2regsel = 3'd4; #1;
    chk("pre_rst_busy3", read1busy, 1);
    rst = 1'b1; rsv = 1'b1; rsvregsel = 3'd3;
    tick();
    rst = 1'b0; rsv = 1'b0; #1;
    chk("rst_pend_err", err, 0);
    chk("rst_pend_busy3", read1busy, 0);
    chk("rst_pend_data4", read2data, 0);
    tick();
    chk("rst_pend_err2", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
